// File: rtl/vc_arbiter_d.sv
// vc_arbiter_d: drains the VC0/VC1 FIFOs with strict VC0 priority and
// routes each word to the D0 or D1 FIFO based on its destination bit.
// Stalls on any destination almost-full/full flag and counts words
// forwarded from each VC.
module vc_arbiter_d #(
  parameter int unsigned data_width = 6,
  parameter int unsigned dest_bit   = 4,
  parameter int unsigned cnt_width  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  empty_fifo_VC0,
  input  logic                  empty_fifo_VC1,
  input  logic [data_width-1:0] data_out_VC0,
  input  logic [data_width-1:0] data_out_VC1,
  input  logic                  almost_full_D0,
  input  logic                  almost_full_D1,
  input  logic                  full_D0,
  input  logic                  full_D1,
  output logic                  rd_enable_VC0,
  output logic                  rd_enable_VC1,
  output logic                  wr_enable_D0,
  output logic                  wr_enable_D1,
  output logic [data_width-1:0] data_in_D,
  output logic [cnt_width-1:0]  cnt_VC0,
  output logic [cnt_width-1:0]  cnt_VC1,
  output logic                  idle
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t                state;
  logic                  clear;
  logic                  stall;
  logic                  any_req;
  logic                  run;
  logic                  valid;
  logic                  src;
  logic [data_width-1:0] word;

  // Clear, stall and pop qualification.
  always_comb begin
    clear   = !reset || !init;
    // The destination of the next word is not known until after the read,
    // so any destination flag blocks popping.
    stall   = almost_full_D0 || almost_full_D1 || full_D0 || full_D1;
    any_req = !empty_fifo_VC0 || !empty_fifo_VC1;
    // IDLE lets the first pop happen in the cycle a VC goes non-empty.
    run     = (state == RUN) || ((state == IDLE) && any_req && !stall);
    rd_enable_VC0 = !clear && run && !stall && !empty_fifo_VC0;
    rd_enable_VC1 = !clear && run && !stall && empty_fifo_VC0 && !empty_fifo_VC1;
    word    = src ? data_out_VC1 : data_out_VC0;
    idle    = (state == IDLE) && !valid;
  end

  // Control FSM, read pipeline, push registers and per-VC counters.
  always_ff @(posedge clk) begin
    if (!reset || !init) begin
      state        <= IDLE;
      valid        <= 1'b0;
      src          <= 1'b0;
      wr_enable_D0 <= 1'b0;
      wr_enable_D1 <= 1'b0;
      data_in_D    <= '0;
      cnt_VC0      <= '0;
      cnt_VC1      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) state <= stall ? STALL : RUN;
        end
        RUN: begin
          if (stall)                  state <= STALL;
          else if (!any_req && !valid) state <= IDLE;
        end
        STALL: begin
          if (!stall) state <= any_req ? RUN : IDLE;
        end
        default: state <= IDLE;
      endcase

      valid <= rd_enable_VC0 || rd_enable_VC1;
      src   <= rd_enable_VC1;

      // A word popped last cycle is now on the FIFO read port; forward it
      // regardless of stall, since the threshold leaves room for it.
      if (valid) begin
        data_in_D    <= word;
        wr_enable_D0 <= !word[dest_bit];
        wr_enable_D1 <= word[dest_bit];
        if (src) cnt_VC1 <= cnt_VC1 + cnt_width'(1);
        else     cnt_VC0 <= cnt_VC0 + cnt_width'(1);
      end else begin
        wr_enable_D0 <= 1'b0;
        wr_enable_D1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vc_arbiter_d.sv
// Testbench for vc_arbiter_d: models the VC FIFOs, issues directed words,
// and checks every push against a queue of hand-computed expected words.
module tb_vc_arbiter_d;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init = 1'b1;
  logic       empty_fifo_VC0, empty_fifo_VC1;
  logic [5:0] data_out_VC0 = '0;
  logic [5:0] data_out_VC1 = '0;
  logic       almost_full_D0 = 1'b0, almost_full_D1 = 1'b0;
  logic       full_D0 = 1'b0, full_D1 = 1'b0;
  logic       rd_enable_VC0, rd_enable_VC1;
  logic       wr_enable_D0, wr_enable_D1;
  logic [5:0] data_in_D;
  logic [7:0] cnt_VC0, cnt_VC1;
  logic       idle;

  int checks = 0;
  int failures = 0;
  int pushes = 0;

  logic [5:0] mem0 [1024];
  logic [5:0] mem1 [1024];
  int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;
  logic [5:0] exp_q [$];

  always #5 clk = ~clk;

  vc_arbiter_d #(.data_width(6), .dest_bit(4), .cnt_width(8)) dut (
    .clk(clk), .reset(reset), .init(init),
    .empty_fifo_VC0(empty_fifo_VC0), .empty_fifo_VC1(empty_fifo_VC1),
    .data_out_VC0(data_out_VC0), .data_out_VC1(data_out_VC1),
    .almost_full_D0(almost_full_D0), .almost_full_D1(almost_full_D1),
    .full_D0(full_D0), .full_D1(full_D1),
    .rd_enable_VC0(rd_enable_VC0), .rd_enable_VC1(rd_enable_VC1),
    .wr_enable_D0(wr_enable_D0), .wr_enable_D1(wr_enable_D1),
    .data_in_D(data_in_D), .cnt_VC0(cnt_VC0), .cnt_VC1(cnt_VC1),
    .idle(idle)
  );

  // VC FIFO models: read data appears the cycle after the pop.
  assign empty_fifo_VC0 = (wp0 == rp0);
  assign empty_fifo_VC1 = (wp1 == rp1);

  always @(posedge clk) begin
    if (rd_enable_VC0 && rp0 < wp0) begin
      data_out_VC0 <= mem0[rp0];
      rp0 <= rp0 + 1;
    end
    if (rd_enable_VC1 && rp1 < wp1) begin
      data_out_VC1 <= mem1[rp1];
      rp1 <= rp1 + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every push must match the oldest expected word and its route.
  always @(negedge clk) begin
    #2;
    checks++;
    if (rd_enable_VC0 && rd_enable_VC1) begin
      failures++;
      $display("FAIL rd_both got=1 exp=0 at %0t", $time);
    end
    checks++;
    if ((rd_enable_VC0 && empty_fifo_VC0) || (rd_enable_VC1 && empty_fifo_VC1)) begin
      failures++;
      $display("FAIL rd_empty got=1 exp=0 at %0t", $time);
    end
    if (wr_enable_D0 && wr_enable_D1) begin
      checks++;
      failures++;
      $display("FAIL wr_both got=1 exp=0 at %0t", $time);
    end else if (wr_enable_D0 || wr_enable_D1) begin
      logic [5:0] e;
      pushes++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_push got=%0h exp=none at %0t", data_in_D, $time);
      end else begin
        e = exp_q.pop_front();
        if (data_in_D !== e || wr_enable_D1 !== e[4]) begin
          failures++;
          $display("FAIL push got=%0h/D%0d exp=%0h/D%0d at %0t",
                   data_in_D, wr_enable_D1, e, e[4], $time);
        end
      end
    end
  end

  task automatic load(input int vc, input logic [5:0] d, input bit expect_push);
    if (vc == 0) begin mem0[wp0] = d; wp0++; end
    else         begin mem1[wp1] = d; wp1++; end
    if (expect_push) exp_q.push_back(d);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && idle && empty_fifo_VC0 && empty_fifo_VC1) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_drain_timeout"}, (n >= budget) ? 1 : 0, 0);
  endtask

  initial begin
    int p_before;
    int resumed;
    // Reset held with VC0 non-empty: nothing pops, all outputs cleared.
    @(negedge clk);
    load(0, 6'h3F, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("rst_rd0", rd_enable_VC0, 0);
      check("rst_wr", {wr_enable_D1, wr_enable_D0}, 0);
      check("rst_data", data_in_D, 0);
      check("rst_cnt", {cnt_VC1, cnt_VC0}, 0);
    end
    wp0 = rp0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_idle", idle, 1);
    @(negedge clk); #1;
    check("rst_idle2", idle, 1);

    // Single word: pop in cycle 0, push to D1 in cycle 2.
    load(0, 6'h10, 1'b1);
    #1;
    check("single_rd0", rd_enable_VC0, 1);
    check("single_rd1", rd_enable_VC1, 0);
    @(negedge clk); #1;
    check("single_c1_wr", {wr_enable_D1, wr_enable_D0}, 0);
    @(negedge clk); #1;
    check("single_wr1", wr_enable_D1, 1);
    check("single_wr0", wr_enable_D0, 0);
    check("single_data", data_in_D, 6'h10);
    drain("single", 20);
    check("single_cnt0", cnt_VC0, 1);

    // Priority: three VC0 words pop before both VC1 words.
    load(0, 6'h01, 1'b1); load(0, 6'h12, 1'b1); load(0, 6'h23, 1'b1);
    load(1, 6'h34, 1'b0); load(1, 6'h05, 1'b0);
    exp_q.push_back(6'h34); exp_q.push_back(6'h05);
    #1;
    for (int k = 0; k < 5; k++) begin
      check("prio_rd0", rd_enable_VC0, (k < 3) ? 1 : 0);
      check("prio_rd1", rd_enable_VC1, (k >= 3) ? 1 : 0);
      @(negedge clk); #1;
    end
    drain("prio", 20);
    check("prio_cnt0", cnt_VC0, 4);
    check("prio_cnt1", cnt_VC1, 2);

    // Backpressure: stall after two pops; both in-flight words still land.
    for (int k = 1; k <= 6; k++) load(0, 6'(k), 1'b1);
    @(negedge clk);
    @(negedge clk);
    almost_full_D0 = 1'b1;
    #1;
    p_before = pushes;
    check("bp_rd_drop", rd_enable_VC0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check("bp_rd_held", rd_enable_VC0 | rd_enable_VC1, 0);
    end
    check("bp_inflight_pushes", pushes - p_before, 2);
    almost_full_D0 = 1'b0;
    #1;
    resumed = rd_enable_VC0;
    if (!resumed) begin
      @(negedge clk); #1;
      resumed = rd_enable_VC0;
    end
    check("bp_resume", resumed, 1);
    drain("bp", 30);
    check("bp_cnt0", cnt_VC0, 10);

    // Routing: alternating destinations from VC1.
    for (int k = 0; k < 6; k++) load(1, (k % 2 == 0) ? 6'h0F : 6'h1F, 1'b1);
    drain("route", 30);
    check("route_cnt1", cnt_VC1, 8);

    // Reset the cycle after a pop: the word is dropped and counters clear.
    load(0, 6'h15, 1'b0);
    #1;
    check("midrst_rd0", rd_enable_VC0, 1);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check("midrst_wr", {wr_enable_D1, wr_enable_D0}, 0);
      check("midrst_cnt", {cnt_VC1, cnt_VC0}, 0);
    end
    reset = 1'b1;
    @(negedge clk); #1;
    check("midrst_wr_after", {wr_enable_D1, wr_enable_D0}, 0);
    check("midrst_idle", idle, 1);

    // Counter wrap: 256 VC1 words bring cnt_VC1 back to 0.
    for (int k = 0; k < 256; k++) load(1, 6'(k), 1'b1);
    @(negedge clk); #1;
    drain("wrap", 400);
    check("wrap_cnt1", cnt_VC1, 0);
    check("wrap_cnt0", cnt_VC0, 0);

    // init=0 acts as a soft clear.
    load(0, 6'h2A, 1'b1);
    drain("init", 20);
    check("init_pre_cnt0", cnt_VC0, 1);
    init = 1'b0;
    #1;
    check("init_rd_forced", rd_enable_VC0 | rd_enable_VC1, 0);
    @(negedge clk); #1;
    check("init_cnt0", cnt_VC0, 0);
    init = 1'b1;
    @(negedge clk); #1;
    check("init_idle", idle, 1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
